// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator.
// Optional feature macro: PROD_ACC_SAT_EN (saturating accumulator).
package prod_acc_pkg;

    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/prod_acc_add.sv
// Combinational accumulator adder with carry-out.
// PROD_ACC_SAT_EN defined: clamp to all-ones on carry; otherwise wrap.
module prod_acc_add
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry = raw[ACC_W];
`ifdef PROD_ACC_SAT_EN
        sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
        sum   = raw[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates a stream of 16-bit products into one sum per vector.
// Overflow handling selected by macro PROD_ACC_SAT_EN (see prod_acc_add).
module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             take;
    logic [ACC_W-1:0] sum;
    logic             carry;

    assign take = in_valid && in_ready;

    prod_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc   (acc),
        .prod  (in_prod),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, ACCUM: begin
                if (take) begin
                    state_nx = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    // First term of a vector restarts the sum; later terms add onto it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (take) begin
            if (state == IDLE) begin
                acc   <= ACC_W'(in_prod);
                count <= CNT_W'(1);
                ovf   <= 1'b0;
            end else begin
                acc   <= sum;
                count <= (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
                ovf   <= ovf | carry;
            end
        end
    end

    assign out_acc   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed and randomised checks of prod_accumulator (default, ACC_W=16, CNT_W=2).
// Expected values follow the PROD_ACC_SAT_EN macro of the build.
module tb_prod_accumulator;

`ifdef PROD_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic        rdy_a, val_a, ovf_a;
    logic [23:0] acc_a;
    logic [7:0]  cnt_a;
    logic        rdy_b, val_b, ovf_b;
    logic [15:0] acc_b;
    logic [7:0]  cnt_b;
    logic        rdy_c, val_c, ovf_c;
    logic [23:0] acc_c;
    logic [1:0]  cnt_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prod_accumulator u_dut_a (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (rdy_a),
        .in_prod (in_prod), .in_last (in_last),
        .out_valid (val_a), .out_ready (out_ready),
        .out_acc (acc_a), .out_count (cnt_a), .out_ovf (ovf_a)
    );

    prod_accumulator #(.ACC_W(16)) u_dut_b (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (rdy_b),
        .in_prod (in_prod), .in_last (in_last),
        .out_valid (val_b), .out_ready (out_ready),
        .out_acc (acc_b), .out_count (cnt_b), .out_ovf (ovf_b)
    );

    prod_accumulator #(.CNT_W(2)) u_dut_c (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (rdy_c),
        .in_prod (in_prod), .in_last (in_last),
        .out_valid (val_c), .out_ready (out_ready),
        .out_acc (acc_c), .out_count (cnt_c), .out_ovf (ovf_c)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge after the accepting edge.
    task automatic put(input logic [15:0] p, input logic l);
        bit ok;
        bit r;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        for (int i = 0; i < 40 && !ok; i++) begin
            r = rdy_a;
            @(posedge clk);
            if (r) ok = 1'b1;
            else @(negedge clk);
        end
        check("accept", {31'd0, ok}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [24:0] t;
        logic [23:0] m_acc;
        logic        m_ovf;
        int          n;
        int          k;
        logic [15:0] p;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'd0, val_a}, 0);
        check("rst_acc", {8'd0, acc_a}, 0);
        check("rst_count", {24'd0, cnt_a}, 0);
        check("rst_ovf", {31'd0, ovf_a}, 0);
        check("rst_ready", {31'd0, rdy_a}, 1);

        // 100 + 200 + 300
        out_ready = 1'b1;
        put(16'd100, 1'b0);
        put(16'd200, 1'b0);
        put(16'd300, 1'b1);
        check("v3_valid", {31'd0, val_a}, 1);
        check("v3_ready", {31'd0, rdy_a}, 0);
        check("v3_acc", {8'd0, acc_a}, 600);
        check("v3_count", {24'd0, cnt_a}, 3);
        check("v3_ovf", {31'd0, ovf_a}, 0);
        @(negedge clk);
        check("v3_idle_valid", {31'd0, val_a}, 0);
        check("v3_idle_ready", {31'd0, rdy_a}, 1);

        // single term under backpressure, offered input ignored
        out_ready = 1'b0;
        put(16'd65025, 1'b1);
        in_valid = 1'b1;
        in_prod  = 16'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, val_a}, 1);
            check("bp_ready", {31'd0, rdy_a}, 0);
            check("bp_acc", {8'd0, acc_a}, 65025);
            check("bp_count", {24'd0, cnt_a}, 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_still_valid", {31'd0, val_a}, 1);
        @(negedge clk);
        check("bp_release", {31'd0, val_a}, 0);

        // overflow of a 16-bit accumulator
        put(16'd65000, 1'b0);
        put(16'd1000, 1'b1);
        check("ovf16_flag", {31'd0, ovf_b}, 1);
        check("ovf16_acc", {16'd0, acc_b}, SAT ? 32'd65535 : 32'd464);
        check("ovf24_acc", {8'd0, acc_a}, 66000);
        check("ovf24_flag", {31'd0, ovf_a}, 0);
        @(negedge clk);

        // clamp persists; wrap keeps going
        put(16'd65535, 1'b0);
        put(16'd10, 1'b0);
        put(16'd0, 1'b1);
        check("clamp16_acc", {16'd0, acc_b}, SAT ? 32'd65535 : 32'd9);
        check("clamp16_ovf", {31'd0, ovf_b}, 1);
        check("clamp24_acc", {8'd0, acc_a}, 65545);
        check("clamp_count", {24'd0, cnt_a}, 3);
        @(negedge clk);

        // count saturation with CNT_W=2
        for (int i = 0; i < 5; i++) put(16'd1, (i == 4));
        check("csat_count", {30'd0, cnt_c}, 3);
        check("csat_acc", {8'd0, acc_c}, 5);
        check("csat_count8", {24'd0, cnt_a}, 5);
        @(negedge clk);

        // bubbles and zero-valued terms
        put(16'd5, 1'b0);
        idle(3);
        check("bub_valid", {31'd0, val_a}, 0);
        put(16'd0, 1'b0);
        idle(1);
        put(16'd6, 1'b1);
        check("bub_acc", {8'd0, acc_a}, 11);
        check("bub_count", {24'd0, cnt_a}, 3);
        @(negedge clk);

        // reset mid-vector, with a term offered during reset
        put(16'd1, 1'b0);
        put(16'd2, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 16'd50;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mrst_valid", {31'd0, val_a}, 0);
        check("mrst_acc", {8'd0, acc_a}, 0);
        check("mrst_count", {24'd0, cnt_a}, 0);
        check("mrst_ready", {31'd0, rdy_a}, 1);
        idle(2);
        check("mrst_no_out", {31'd0, val_a}, 0);
        put(16'd7, 1'b0);
        put(16'd8, 1'b1);
        check("mrst_new_acc", {8'd0, acc_a}, 15);
        check("mrst_new_count", {24'd0, cnt_a}, 2);
        @(negedge clk);

        // reset while holding a result
        out_ready = 1'b0;
        put(16'd9, 1'b1);
        check("hrst_pre", {31'd0, val_a}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hrst_valid", {31'd0, val_a}, 0);
        check("hrst_acc", {8'd0, acc_a}, 0);
        check("hrst_ready", {31'd0, rdy_a}, 1);

        // randomised vectors against a software model
        out_ready = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            n     = $urandom_range(1, 6);
            m_acc = '0;
            m_ovf = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) begin
                p = 16'($urandom_range(0, 65535));
                t = {1'b0, m_acc} + {9'd0, p};
                if (t[24]) m_ovf = 1'b1;
                m_acc = (t[24] && SAT) ? 24'hffffff : t[23:0];
                put(p, (j == n - 1));
                if (j != n - 1) begin
                    k = $urandom_range(0, 2);
                    idle(k);
                end
            end
            check("rnd_valid", {31'd0, val_a}, 1);
            check("rnd_acc", {8'd0, acc_a}, {8'd0, m_acc});
            check("rnd_count", {24'd0, cnt_a}, n);
            check("rnd_ovf", {31'd0, ovf_a}, {31'd0, m_ovf});
            if (!out_ready) begin
                k = $urandom_range(1, 3);
                idle(k);
                check("rnd_hold_acc", {8'd0, acc_a}, {8'd0, m_acc});
                out_ready = 1'b1;
            end
            @(negedge clk);
            check("rnd_idle", {31'd0, val_a}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, giving the accumulator width in bits (minimum 16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the term-counter width in bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_prod/in_last are valid.
REQ-007 in_ready  output  1  block accepts a term this cycle.
REQ-008 in_prod  input  16  unsigned 8x8 approximate product, one term.
REQ-009 in_last  input  1  this term is the final term of the vector.
REQ-010 out_valid  output  1  out_acc/out_count/out_ovf hold a finished sum.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_acc  output  ACC_W  accumulated sum.
REQ-013 out_count  output  CNT_W  number of terms accepted for this sum.
REQ-014 out_ovf  output  1  sticky flag: sum exceeded 2^ACC_W-1 at least once.

Function
REQ-015 A term SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-017 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1.
REQ-018 An accepted term in IDLE SHALL load acc=zero-extended in_prod, count=1 and ovf=0.
REQ-019 An accepted term in ACCUM SHALL set acc=acc+in_prod, count=count+1, and ovf=ovf OR carry-out.
REQ-020 An accepted term with in_last=0 SHALL move the FSM to ACCUM (or keep it there).
REQ-021 An accepted term with in_last=1 SHALL move the FSM to HOLD.
REQ-022 out_valid SHALL rise on the cycle after the last term is accepted (latency 1), with the final values registered.
REQ-023 out_acc/out_count/out_ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 HOLD with out_ready=1 SHALL go to IDLE on the next edge.
REQ-025 No term SHALL be accepted in the handoff cycle of REQ-024; IDLE's in_ready applies from the following cycle.
REQ-026 count SHALL saturate at 2^CNT_W-1 rather than wrap; accumulation SHALL continue past saturation.
REQ-027 in_valid=0 in ACCUM SHALL hold all state; bubbles between terms are legal.
REQ-028 in_prod=0 SHALL still be counted as a term.

Reset
REQ-029 While rst=1 at a clock edge, the FSM SHALL go to IDLE and acc, count and ovf SHALL clear to 0.
REQ-030 Reset outputs SHALL be out_valid=0, out_acc=0, out_count=0, out_ovf=0 and in_ready=1 from the first cycle after reset.
REQ-031 Reset mid-vector or in HOLD SHALL discard the partial or unconsumed result, with no output emitted.
REQ-032 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-033 The accumulator's overflow behaviour SHALL be selected by the macro PROD_ACC_SAT_EN.
REQ-034 With PROD_ACC_SAT_EN defined, an addition with carry-out SHALL clamp acc to 2^ACC_W-1, and acc SHALL stay clamped for later terms.
REQ-035 Without PROD_ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_W.
REQ-036 out_ovf SHALL behave identically in both builds.

Structure
REQ-037 Package prod_acc_pkg SHALL hold the FSM state enum (IDLE/ACCUM/HOLD), the PROD_W=16 constant and the default ACC_W/CNT_W constants.
REQ-038 The adder SHALL be one sub-module, prod_acc_add, a combinational ACC_W-bit add with carry-out and macro-controlled clamping.
REQ-039 The FSM, counter and output registers SHALL reside in prod_accumulator.

Verification
REQ-040 Terms 100, 200, 300 (last on 300), out_ready=1 -> out_valid the cycle after 300 is accepted; out_acc=600, out_count=3, out_ovf=0; IDLE two cycles later.
REQ-041 Single term 65025 with in_last=1 -> out_acc=65025, out_count=1; hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-042 ACC_W=16, terms 65000 then 1000 (last) -> out_ovf=1; out_acc=464 without PROD_ACC_SAT_EN, 65535 with it.
REQ-043 CNT_W=2, five terms of 1 -> out_count=3 (saturated), out_acc=5.
REQ-044 Assert rst after two of four terms -> no out_valid; a new vector 7, 8 (last) -> out_acc=15, out_count=2.
REQ-045 Random in_valid bubbles and out_ready backpressure over 1000 vectors -> sums match a software model, with no lost or duplicated terms.
